// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Frame FSM states and data width used by the rx sequencer and its interface.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// Bundle of the serial line, frame options and receive/parity-checker outputs.
// The slave modport is the receiver; the master modport is whatever drives the line.
interface uart_rx_sequencer_if;
    import uart_pkg::*;

    logic                 rx;
    logic                 par_en;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 framing_error;
    logic                 busy;
    logic [DATA_BITS-1:0] pc_data;
    logic                 pc_parity_bit;
    logic                 pc_check;

    modport master (
        output rx, par_en,
        input  rx_data, rx_valid, framing_error, busy,
        input  pc_data, pc_parity_bit, pc_check
    );

    modport slave (
        input  rx, par_en,
        output rx_data, rx_valid, framing_error, busy,
        output pc_data, pc_parity_bit, pc_check
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one-cycle tick every CLK_DIV clocks, held at zero while clr is high.
// With CLK_DIV=1 the counter stays at zero and tick is asserted every cycle.
module uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: synchronises rx, walks start/data/parity/stop on mid-bit samples,
// and hands good bytes to the consumer and, for parity frames, to the parity checker.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16
) (
    input logic               clk,
    input logic               reset,
    uart_rx_sequencer_if.slave bus
);

    localparam int                    TW    = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]         TLAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0]         THALF = TW'(OVERSAMPLE / 2 - 1);
    localparam int                    BW    = $clog2(DATA_BITS);
    localparam logic [BW-1:0]         BLAST = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_l;
    logic                 parity_q;
    logic                 clr;
    logic                 tick;
    logic                 bit_end;

    // Two-flop synchroniser; idles high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    assign clr     = (state == IDLE);
    assign bit_end = tick && (tcnt == TLAST);

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    // Frame FSM; the stop sample lands mid-bit, so returning to IDLE there still catches
    // a start edge that follows immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            tcnt              <= '0;
            bit_cnt           <= '0;
            shift             <= '0;
            par_l             <= 1'b0;
            parity_q          <= 1'b0;
            bus.rx_data       <= '0;
            bus.rx_valid      <= 1'b0;
            bus.framing_error <= 1'b0;
            bus.busy          <= 1'b0;
            bus.pc_data       <= '0;
            bus.pc_parity_bit <= 1'b0;
            bus.pc_check      <= 1'b0;
        end else begin
            bus.rx_valid      <= 1'b0;
            bus.framing_error <= 1'b0;
            bus.pc_check      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tcnt     <= '0;
                        bit_cnt  <= '0;
                        par_l    <= bus.par_en;
                        bus.busy <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tcnt == THALF) begin
                            tcnt <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                state    <= IDLE;
                                bus.busy <= 1'b0;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) tcnt <= bit_end ? '0 : tcnt + 1'b1;
                    if (bit_end) begin
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BLAST) begin
                            state <= par_l ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) tcnt <= bit_end ? '0 : tcnt + 1'b1;
                    if (bit_end) begin
                        parity_q <= rx_s;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (tick) tcnt <= bit_end ? '0 : tcnt + 1'b1;
                    if (bit_end) begin
                        if (rx_s) begin
                            bus.rx_valid <= 1'b1;
                            bus.rx_data  <= shift;
                            if (par_l) begin
                                bus.pc_check      <= 1'b1;
                                bus.pc_data       <= shift;
                                bus.pc_parity_bit <= parity_q;
                            end
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            bus.framing_error <= 1'b1;
                            state             <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Self-checking bench for uart_rx_sequencer: table of frames plus hand-written corner cases,
// with expected output events queued as frames are driven and matched as the DUT emits them.
module tb_uart_rx_sequencer;
    import uart_pkg::*;

    localparam int OS    = 16;
    localparam int DIV_B = 27;

    typedef struct {
        logic [7:0] data;
        bit         par_en;
        bit         par_bit;
        bit         stop_bit;
        bit         exp_valid;
        bit         exp_ferr;
        bit         exp_pc;
    } vec_t;

    typedef struct {
        bit         which;
        bit         valid;
        bit         ferr;
        bit         pc;
        logic [7:0] data;
        logic [7:0] pc_data;
        bit         pc_par;
    } event_t;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    event_t     exp_q[$];
    event_t     obs_q[$];
    logic [7:0] last_good [2];
    logic [7:0] last_pcd  [2];
    bit         last_pcp  [2];
    vec_t       vecs [8];

    always #5 clk = ~clk;

    uart_rx_sequencer_if bus_a();
    uart_rx_sequencer_if bus_b();

    uart_rx_sequencer #(.CLK_DIV(1), .OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    uart_rx_sequencer #(.CLK_DIV(DIV_B), .OVERSAMPLE(OS)) dut_slow (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Record every output pulse; a stretched pulse shows up as an extra event
    always @(negedge clk) begin
        if (bus_a.rx_valid || bus_a.framing_error || bus_a.pc_check)
            obs_q.push_back('{1'b0, bus_a.rx_valid, bus_a.framing_error, bus_a.pc_check,
                              bus_a.rx_data, bus_a.pc_data, bus_a.pc_parity_bit});
        if (bus_b.rx_valid || bus_b.framing_error || bus_b.pc_check)
            obs_q.push_back('{1'b1, bus_b.rx_valid, bus_b.framing_error, bus_b.pc_check,
                              bus_b.rx_data, bus_b.pc_data, bus_b.pc_parity_bit});
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, actual, expected);
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) bus_b.rx = v;
        else     bus_a.rx = v;
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        set_rx(sel, v);
        repeat (sel ? OS * DIV_B : OS) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data, input bit par_en,
                              input bit par_bit, input bit stop_bit);
        if (sel) bus_b.par_en = par_en;
        else     bus_a.par_en = par_en;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
        if (par_en) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
    endtask

    // Expected event built from the bench's own record of what the outputs should hold
    task automatic push_expect(input bit sel, input logic [7:0] data, input bit valid,
                               input bit ferr, input bit pc, input bit par_bit);
        if (valid) last_good[sel] = data;
        if (pc) begin
            last_pcd[sel] = data;
            last_pcp[sel] = par_bit;
        end
        exp_q.push_back('{sel, valid, ferr, pc, last_good[sel], last_pcd[sel], last_pcp[sel]});
    endtask

    task automatic applyStimulus(input bit sel, input vec_t v);
        if (v.exp_valid || v.exp_ferr)
            push_expect(sel, v.data, v.exp_valid, v.exp_ferr, v.exp_pc, v.par_bit);
        send_frame(sel, v.data, v.par_en, v.par_bit, v.stop_bit);
        set_rx(sel, 1'b1);
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? bus_b.busy : bus_a.busy) && n < 40 * OS * DIV_B) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", 32'(sel ? bus_b.busy : bus_a.busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic drain_scoreboard();
        event_t e;
        event_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing_event got none want valid=%0d ferr=%0d data=%0h",
                         e.valid, e.ferr, e.data);
            end else begin
                o = obs_q.pop_front();
                checkOutput("event_dut",     32'(o.which),   32'(e.which));
                checkOutput("rx_valid",      32'(o.valid),   32'(e.valid));
                checkOutput("framing_error", 32'(o.ferr),    32'(e.ferr));
                checkOutput("pc_check",      32'(o.pc),      32'(e.pc));
                checkOutput("rx_data",       32'(o.data),    32'(e.data));
                checkOutput("pc_data",       32'(o.pc_data), 32'(e.pc_data));
                checkOutput("pc_parity_bit", 32'(o.pc_par),  32'(e.pc_par));
            end
        end
        checkOutput("extra_events", 32'(obs_q.size()), 32'd0);
        obs_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_busy"},     32'(bus_a.busy),          32'd0);
        checkOutput({tag, "_rx_data"},  32'(bus_a.rx_data),       32'd0);
        checkOutput({tag, "_rx_valid"}, 32'(bus_a.rx_valid),      32'd0);
        checkOutput({tag, "_ferr"},     32'(bus_a.framing_error), 32'd0);
        checkOutput({tag, "_pc_check"}, 32'(bus_a.pc_check),      32'd0);
        checkOutput({tag, "_pc_data"},  32'(bus_a.pc_data),       32'd0);
        checkOutput({tag, "_pc_par"},   32'(bus_a.pc_parity_bit), 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'h6B, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            last_good[i] = 8'h00;
            last_pcd[i]  = 8'h00;
            last_pcp[i]  = 1'b0;
        end

        bus_a.rx     = 1'b1;
        bus_b.rx     = 1'b1;
        bus_a.par_en = 1'b0;
        bus_b.par_en = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, vecs[i]);
            wait_idle(1'b0);
            drain_scoreboard();
        end

        // Short low glitch must be rejected silently, then a normal frame
        set_rx(1'b0, 1'b0);
        repeat (4) @(negedge clk);
        set_rx(1'b0, 1'b1);
        repeat (40) @(negedge clk);
        checkOutput("glitch_busy", 32'(bus_a.busy), 32'd0);
        drain_scoreboard();
        applyStimulus(1'b0, '{8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        wait_idle(1'b0);
        drain_scoreboard();

        // Stop bit low and line held low: exactly one framing error
        push_expect(1'b0, 8'hC7, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 8'hC7, 1'b0, 1'b0, 1'b0);
        repeat (40 * OS) @(negedge clk);
        checkOutput("break_busy", 32'(bus_a.busy), 32'd1);
        set_rx(1'b0, 1'b1);
        wait_idle(1'b0);
        drain_scoreboard();
        applyStimulus(1'b0, '{8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        wait_idle(1'b0);
        drain_scoreboard();

        // Reset in the middle of data bit 4 drops the partial byte
        bus_a.par_en = 1'b0;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
        set_rx(1'b0, 1'b0);
        repeat (OS / 2) @(negedge clk);
        reset = 1'b1;
        set_rx(1'b0, 1'b1);
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        last_good[0] = 8'h00;
        last_pcd[0]  = 8'h00;
        last_pcp[0]  = 1'b0;
        repeat (20 * OS) @(negedge clk);
        drain_scoreboard();
        applyStimulus(1'b0, '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        wait_idle(1'b0);
        drain_scoreboard();

        // Back-to-back frames with no idle gap on the slow-prescaler instance
        push_expect(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        push_expect(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        set_rx(1'b1, 1'b1);
        wait_idle(1'b1);
        drain_scoreboard();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
